// File: rtl/axistream_packet_arbiter.sv
// Packet-granular round-robin arbiter: several AXI-Stream initiators share one
// registered target port, and a grant is held from the first beat up to tlast.
module axistream_packet_arbiter #(
   parameter int NumRequesters         = 4,
   parameter int AxiStreamIfTDataWidth = 32,
   parameter int AxiStreamIfTIdWidth   = 5,
   parameter int AxiStreamIfTDestWidth = 5
) (
   input  logic                                             clk_axis_i,
   input  logic                                             rst_axis_ni,
   input  logic [NumRequesters-1:0]                         requester_enable_i,
   input  logic [NumRequesters-1:0]                         s_axis_tvalid_i,
   output logic [NumRequesters-1:0]                         s_axis_tready_o,
   input  logic [NumRequesters*AxiStreamIfTDataWidth-1:0]   s_axis_tdata_i,
   input  logic [NumRequesters-1:0]                         s_axis_tlast_i,
   input  logic [NumRequesters*AxiStreamIfTIdWidth-1:0]     s_axis_tid_i,
   input  logic [NumRequesters*AxiStreamIfTDestWidth-1:0]   s_axis_tdest_i,
   output logic                                             m_axis_tvalid_o,
   input  logic                                             m_axis_tready_i,
   output logic [AxiStreamIfTDataWidth-1:0]                 m_axis_tdata_o,
   output logic                                             m_axis_tlast_o,
   output logic [AxiStreamIfTIdWidth-1:0]                   m_axis_tid_o,
   output logic [AxiStreamIfTDestWidth-1:0]                 m_axis_tdest_o,
   output logic [NumRequesters-1:0]                         grant_o,
   output logic                                             busy_o
);

   localparam int N    = NumRequesters;
   localparam int DW   = AxiStreamIfTDataWidth;
   localparam int IW   = AxiStreamIfTIdWidth;
   localparam int TW   = AxiStreamIfTDestWidth;
   localparam int IdxW = $clog2(NumRequesters);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e            state_r;
   state_e            state_next_s;
   logic [N-1:0]      grant_r;
   logic [IdxW-1:0]   last_grant_r;

   logic [N-1:0]      req_s;
   logic [IdxW-1:0]   cand_s;
   logic [IdxW-1:0]   pick_idx_s;
   logic              pick_found_s;
   logic [N-1:0]      grant_pick_s;

   logic [DW-1:0]     sel_tdata_s;
   logic              sel_tlast_s;
   logic [IW-1:0]     sel_tid_s;
   logic [TW-1:0]     sel_tdest_s;
   logic              sel_tvalid_s;

   logic              out_free_s;
   logic [N-1:0]      tready_s;
   logic              accept_s;
   logic              pkt_end_s;

   logic              m_tvalid_r;
   logic [DW-1:0]     m_tdata_r;
   logic              m_tlast_r;
   logic [IW-1:0]     m_tid_r;
   logic [TW-1:0]     m_tdest_r;

   assign req_s        = s_axis_tvalid_i & requester_enable_i;
   assign out_free_s   = ~m_tvalid_r | m_axis_tready_i;
   assign accept_s     = |(s_axis_tvalid_i & tready_s);
   assign pkt_end_s    = accept_s & sel_tlast_s;
   assign grant_pick_s = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      cand_s       = '0;
      for (int i = 1; i <= N; i++) begin
         cand_s = IdxW'((int'(last_grant_r) + i) % N);
         if (!pick_found_s && req_s[cand_s]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = cand_s;
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // AND-OR payload mux driven by the one-hot grant.
   always_comb begin
      sel_tdata_s  = '0;
      sel_tlast_s  = 1'b0;
      sel_tid_s    = '0;
      sel_tdest_s  = '0;
      sel_tvalid_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         sel_tdata_s  = sel_tdata_s  | (s_axis_tdata_i[k*DW +: DW] & {DW{grant_r[k]}});
         sel_tid_s    = sel_tid_s    | (s_axis_tid_i[k*IW +: IW]   & {IW{grant_r[k]}});
         sel_tdest_s  = sel_tdest_s  | (s_axis_tdest_i[k*TW +: TW] & {TW{grant_r[k]}});
         sel_tlast_s  = sel_tlast_s  | (s_axis_tlast_i[k]  & grant_r[k]);
         sel_tvalid_s = sel_tvalid_s | (s_axis_tvalid_i[k] & grant_r[k]);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin
      if (!rst_axis_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) begin
               state_next_s = ST_LOCKED;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (pkt_end_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_LOCKED;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: tready only toward the granted requester while the slot is free.
   always_comb begin
      tready_s = '0;
      case (state_r)
         ST_IDLE:   tready_s = '0;
         ST_LOCKED: tready_s = grant_r & {N{out_free_s}};
         default:   tready_s = '0;
      endcase
   end

   // Grant and round-robin pointer registers.
   always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin
      if (!rst_axis_ni) begin
         grant_r      <= '0;
         last_grant_r <= IdxW'(N - 1);
      end else if ((state_r == ST_IDLE) && pick_found_s) begin
         grant_r      <= grant_pick_s;
         last_grant_r <= pick_idx_s;
      end else if ((state_r == ST_LOCKED) && pkt_end_s) begin
         grant_r      <= '0;
      end
   end

   // Output register refills in the same cycle it drains, keeping 1 beat/cycle.
   always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin
      if (!rst_axis_ni) begin
         m_tvalid_r <= 1'b0;
         m_tdata_r  <= '0;
         m_tlast_r  <= 1'b0;
         m_tid_r    <= '0;
         m_tdest_r  <= '0;
      end else if (accept_s) begin
         m_tvalid_r <= 1'b1;
         m_tdata_r  <= sel_tdata_s;
         m_tlast_r  <= sel_tlast_s;
         m_tid_r    <= sel_tid_s;
         m_tdest_r  <= sel_tdest_s;
      end else if (m_axis_tready_i) begin
         m_tvalid_r <= 1'b0;
      end
   end

   assign s_axis_tready_o = tready_s;
   assign m_axis_tvalid_o = m_tvalid_r;
   assign m_axis_tdata_o  = m_tdata_r;
   assign m_axis_tlast_o  = m_tlast_r;
   assign m_axis_tid_o    = m_tid_r;
   assign m_axis_tdest_o  = m_tdest_r;
   assign grant_o         = grant_r;
   assign busy_o          = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_axistream_packet_arbiter.sv
// Directed bench for axistream_packet_arbiter: per-scenario tasks with
// hand-computed cycle tables and a small packet-source model.
module tb_axistream_packet_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 5;
   localparam int TW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      enable;
   logic [N-1:0]      s_tvalid;
   logic [N-1:0]      s_tready;
   logic [N*DW-1:0]   s_tdata;
   logic [N-1:0]      s_tlast;
   logic [N*IW-1:0]   s_tid;
   logic [N*TW-1:0]   s_tdest;
   logic              m_tvalid;
   logic              m_ready;
   logic [DW-1:0]     m_tdata;
   logic              m_tlast;
   logic [IW-1:0]     m_tid;
   logic [TW-1:0]     m_tdest;
   logic [N-1:0]      grant;
   logic              busy;

   always #5 clk = ~clk;

   axistream_packet_arbiter #(
      .NumRequesters(N), .AxiStreamIfTDataWidth(DW),
      .AxiStreamIfTIdWidth(IW), .AxiStreamIfTDestWidth(TW)
   ) dut (
      .clk_axis_i(clk), .rst_axis_ni(rst_n), .requester_enable_i(enable),
      .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready), .s_axis_tdata_i(s_tdata),
      .s_axis_tlast_i(s_tlast), .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_tdest),
      .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_ready), .m_axis_tdata_o(m_tdata),
      .m_axis_tlast_o(m_tlast), .m_axis_tid_o(m_tid), .m_axis_tdest_o(m_tdest),
      .grant_o(grant), .busy_o(busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   int src_npkt [N];
   int src_len  [N];
   int src_pkt  [N];
   int src_beat [N];
   logic [DW:0]  out_q[$];
   int           gnt_q[$];
   logic [N-1:0] prev_grant;

   localparam logic [3:0]  T1_GNT [7] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
   localparam logic        T1_MV  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [31:0] T1_MD  [7] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
   localparam logic        T1_ML  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   localparam logic        T3_RDY [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam logic        T3_TR  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic        T3_MV  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic [31:0] T3_MD  [9] = '{32'h0, 32'h0, 32'h111, 32'h111, 32'h111,
                                          32'h122, 32'h133, 32'h144, 32'h0};

   localparam int T4_K [8] = '{0, 1, 3, 0, 1, 3, 1, 3};
   localparam int T4_P [8] = '{0, 0, 0, 1, 1, 1, 2, 2};

   // Beat payload: 0x11*(beat+1) + 0x100*requester + 0x1000*packet.
   function automatic logic [DW-1:0] dval(input int k, input int p, input int b);
      return 32'h11 * 32'(b + 1) + 32'h100 * 32'(k) + 32'h1000 * 32'(p);
   endfunction

   task automatic drive_src();
      for (int k = 0; k < N; k++) begin
         s_tvalid[k]            = (src_pkt[k] < src_npkt[k]);
         s_tdata[k*DW +: DW]    = dval(k, src_pkt[k], src_beat[k]);
         s_tlast[k]             = (src_beat[k] == src_len[k] - 1);
         s_tid[k*IW +: IW]      = IW'(k + 3);
         s_tdest[k*TW +: TW]    = TW'(k + 20);
      end
   endtask

   task automatic clear_src();
      for (int k = 0; k < N; k++) begin
         src_npkt[k] = 0; src_len[k] = 1; src_pkt[k] = 0; src_beat[k] = 0;
      end
      drive_src();
      out_q.delete();
      gnt_q.delete();
      prev_grant = '0;
   endtask

   // One clock: log handshakes seen at the negedge, advance sources, record new grants.
   task automatic tick();
      logic [N-1:0] hs;
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_ready) out_q.push_back({m_tlast, m_tdata});
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         if (hs[k]) begin
            if (src_beat[k] == src_len[k] - 1) begin
               src_beat[k] = 0;
               src_pkt[k]  = src_pkt[k] + 1;
            end else begin
               src_beat[k] = src_beat[k] + 1;
            end
         end
      end
      drive_src();
      if (prev_grant == '0 && grant != '0) begin
         for (int k = 0; k < N; k++) if (grant[k]) gnt_q.push_back(k);
      end
      prev_grant = grant;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      enable  = 4'b1111;
      m_ready = 1'b1;
      clear_src();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 4'b1111; m_ready = 1'b1;
      clear_src();
      @(negedge clk);
      n_vec++;
      if ({grant, busy, s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got grant=%b busy=%b trdy=%b mv=%b data=%h last=%b id=%h dest=%h want all 0",
                  grant, busy, s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest);
      end
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle got grant=%b mv=%b want 0000 0", grant, m_tvalid);
      end
   endtask

   task automatic test_single_packet();
      do_reset();
      src_npkt[0] = 1; src_len[0] = 3;
      drive_src();
      for (int c = 0; c < 7; c++) begin
         n_vec++;
         if (grant !== T1_GNT[c] || busy !== (T1_GNT[c] != 4'h0)) begin
            n_bad++;
            $display("FAIL t1_grant c=%0d got %b/%b want %b", c, grant, busy, T1_GNT[c]);
         end
         n_vec++;
         if (s_tready[0] !== T1_GNT[c][0]) begin
            n_bad++;
            $display("FAIL t1_tready c=%0d got %b want %b", c, s_tready[0], T1_GNT[c][0]);
         end
         n_vec++;
         if (m_tvalid !== T1_MV[c]) begin
            n_bad++;
            $display("FAIL t1_mvalid c=%0d got %b want %b", c, m_tvalid, T1_MV[c]);
         end
         if (T1_MV[c]) begin
            n_vec++;
            if (m_tdata !== T1_MD[c] || m_tlast !== T1_ML[c] || m_tid !== 5'd3 || m_tdest !== 5'd20) begin
               n_bad++;
               $display("FAIL t1_beat c=%0d got %h/%b/%0d/%0d want %h/%b/3/20",
                        c, m_tdata, m_tlast, m_tid, m_tdest, T1_MD[c], T1_ML[c]);
            end
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_g;
      logic [DW:0] exp_b;
      logic [DW:0] got_b;
      int j;
      int ph;
      do_reset();
      for (int k = 0; k < N; k++) begin src_npkt[k] = 2; src_len[k] = 2; end
      drive_src();
      for (int c = 0; c < 27; c++) begin
         exp_g = 4'b0000;
         if (c > 0) begin
            j  = (c - 1) / 3;
            ph = (c - 1) % 3;
            if (j < 8 && ph < 2) exp_g = 4'b0001 << (j % 4);
         end
         n_vec++;
         if (grant !== exp_g) begin
            n_bad++;
            $display("FAIL t2_grant c=%0d got %b want %b", c, grant, exp_g);
         end
         tick();
      end
      n_vec++;
      if (out_q.size() != 16) begin
         n_bad++;
         $display("FAIL t2_beat_count got %0d want 16", out_q.size());
      end
      for (int i = 0; i < 16; i++) begin
         j     = i / 2;
         exp_b = {(i % 2 == 1), dval(j % 4, j / 4, i % 2)};
         got_b = (i < out_q.size()) ? out_q[i] : '1;
         n_vec++;
         if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL t2_beat i=%0d got %h want %h", i, got_b, exp_b);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW:0] got_b;
      do_reset();
      src_npkt[1] = 1; src_len[1] = 4;
      drive_src();
      for (int c = 0; c < 9; c++) begin
         m_ready = T3_RDY[c];
         #1;
         n_vec++;
         if (s_tready[1] !== T3_TR[c]) begin
            n_bad++;
            $display("FAIL t3_tready c=%0d got %b want %b", c, s_tready[1], T3_TR[c]);
         end
         n_vec++;
         if (m_tvalid !== T3_MV[c] || (T3_MV[c] && m_tdata !== T3_MD[c])) begin
            n_bad++;
            $display("FAIL t3_out c=%0d got %b/%h want %b/%h", c, m_tvalid, m_tdata, T3_MV[c], T3_MD[c]);
         end
         tick();
      end
      n_vec++;
      if (out_q.size() != 4) begin
         n_bad++;
         $display("FAIL t3_beat_count got %0d want 4", out_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         got_b = (i < out_q.size()) ? out_q[i] : '1;
         n_vec++;
         if (got_b !== {(i == 3), dval(1, 0, i)}) begin
            n_bad++;
            $display("FAIL t3_beat i=%0d got %h want %h", i, got_b, {(i == 3), dval(1, 0, i)});
         end
      end
   endtask

   task automatic test_enable();
      logic        seen2;
      logic [DW:0] exp_b;
      logic [DW:0] got_b;
      int          got_g;
      do_reset();
      enable = 4'b1011;
      seen2  = 1'b0;
      for (int k = 0; k < N; k++) begin src_npkt[k] = 3; src_len[k] = 2; end
      drive_src();
      for (int c = 0; c < 36; c++) begin
         if (gnt_q.size() == 4 && grant == 4'b0001) enable[0] = 1'b0;
         if (grant[2]) seen2 = 1'b1;
         tick();
      end
      n_vec++;
      if (seen2 !== 1'b0) begin
         n_bad++;
         $display("FAIL t4_disabled_grant got %b want 0", seen2);
      end
      n_vec++;
      if (gnt_q.size() != 8) begin
         n_bad++;
         $display("FAIL t4_grant_count got %0d want 8", gnt_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         got_g = (i < gnt_q.size()) ? gnt_q[i] : -1;
         n_vec++;
         if (got_g != T4_K[i]) begin
            n_bad++;
            $display("FAIL t4_order i=%0d got %0d want %0d", i, got_g, T4_K[i]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         exp_b = {(i % 2 == 1), dval(T4_K[i / 2], T4_P[i / 2], i % 2)};
         got_b = (i < out_q.size()) ? out_q[i] : '1;
         n_vec++;
         if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL t4_beat i=%0d got %h want %h", i, got_b, exp_b);
         end
      end
   endtask

   task automatic test_reset_midpacket();
      int got_g;
      do_reset();
      src_npkt[2] = 1; src_len[2] = 4;
      drive_src();
      repeat (3) tick();
      n_vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h222 || grant !== 4'b0100) begin
         n_bad++;
         $display("FAIL t5_pre got %b/%h/%b want 1/00000222/0100", m_tvalid, m_tdata, grant);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({grant, busy, s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest} !== '0) begin
         n_bad++;
         $display("FAIL t5_in_reset got grant=%b busy=%b trdy=%b mv=%b data=%h last=%b id=%h dest=%h want all 0",
                  grant, busy, s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tdest);
      end
      clear_src();
      for (int k = 1; k < N; k++) begin src_npkt[k] = 1; src_len[k] = 2; end
      drive_src();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (grant !== 4'b0010) begin
         n_bad++;
         $display("FAIL t5_first_grant got %b want 0010", grant);
      end
      repeat (10) tick();
      for (int i = 0; i < 3; i++) begin
         got_g = (i < gnt_q.size()) ? gnt_q[i] : -1;
         n_vec++;
         if (got_g != i + 1) begin
            n_bad++;
            $display("FAIL t5_order i=%0d got %0d want %0d", i, got_g, i + 1);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 4'b1111;
      m_ready = 1'b1;
      clear_src();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_enable();
      test_reset_midpacket();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
